// File: rtl/sort_8x8bit_if.sv
// sort_8x8bit_if: stream-in / stream-out handshake and status bundle for the 8-word sorter
interface sort_8x8bit_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [4:0] swap_count;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy, swap_count);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy, swap_count);
endinterface

// File: rtl/sort_8x8bit.sv
// sort_8x8bit: loads 8 signed words, sorts them by serial odd-even transposition, streams them out ascending
module sort_8x8bit #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  sort_8x8bit_if.slave  s
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t      r_state;
  logic [7:0]  r_buf [DEPTH];
  logic [2:0]  r_wr_idx;
  logic [2:0]  r_rd_idx;
  logic [2:0]  r_phase;
  logic [1:0]  r_pair;
  logic [4:0]  r_swap_count;
  logic [2:0]  w_i;
  logic [2:0]  w_i1;
  logic [7:0]  w_x;
  logic [7:0]  w_y;
  logic        w_r;
  logic        w_last;
  // even phases compare (0,1)(2,3)(4,5)(6,7); odd phases compare (1,2)(3,4)(5,6)
  assign w_i    = {r_pair, 1'b0} + {2'b00, r_phase[0]};
  assign w_i1   = w_i + 3'd1;
  assign w_x    = r_buf[w_i1];
  assign w_y    = r_buf[w_i];
  assign w_r    = $signed(w_x) < $signed(w_y);
  assign w_last = r_phase[0] ? (r_pair == 2'd2) : (r_pair == 2'd3);
  assign s.in_ready   = r_state == LOAD;
  assign s.out_valid  = r_state == DRAIN;
  assign s.busy       = r_state == SORT;
  assign s.out_data   = r_buf[r_rd_idx];
  assign s.swap_count = r_swap_count;
  // frame FSM: load, one compare-and-swap per cycle, then drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_phase      <= '0;
      r_pair       <= '0;
      r_swap_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        LOAD: if (s.in_valid) begin
          r_buf[r_wr_idx] <= s.in_data;
          r_wr_idx        <= r_wr_idx + 3'd1;
          if (r_wr_idx == 3'd7) begin
            r_state      <= SORT;
            r_phase      <= '0;
            r_pair       <= '0;
            r_swap_count <= '0;
          end
        end
        SORT: begin
          if (w_r) begin
            r_buf[w_i]   <= w_x;
            r_buf[w_i1]  <= w_y;
            r_swap_count <= r_swap_count + 5'd1;
          end
          if (w_last) begin
            r_phase <= r_phase + 3'd1;
            r_pair  <= '0;
            if (r_phase == 3'd7) begin
              r_state  <= DRAIN;
              r_rd_idx <= '0;
            end
          end else begin
            r_pair <= r_pair + 2'd1;
          end
        end
        DRAIN: if (s.out_ready) begin
          r_rd_idx <= r_rd_idx + 3'd1;
          if (r_rd_idx == 3'd7) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_8x8bit.sv
// tb_sort_8x8bit: scoreboard bench for the 8-word sorter
module tb_sort_8x8bit;
  logic clk = 1'b0;
  logic rst;
  sort_8x8bit_if s ();
  sort_8x8bit dut (.clk(clk), .rst(rst), .s(s));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];
  int exp_sw = 0;
  int fa[8] = '{7, 6, 5, 4, 3, 2, 1, 0};
  int fb[8] = '{-128, 127, 0, -1, 1, -128, 127, 0};
  int fc[8] = '{-4, -3, -2, -1, 0, 1, 2, 3};
  int fd[8] = '{3, -7, 100, -100, 0, 42, -1, 9};
  int fx[8] = '{9, 8, 7, 6, 5, 4, 3, 2};
  int fe[8] = '{5, 5, 5, 5, 5, 5, 5, -5};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // full: push expected results and time the SORT phase; otherwise just feed 8 words
  task automatic load(input int f[8], input bit hold, input bit full);
    int a[8];
    int tmp, t, n, nb, inv;
    a = f;
    inv = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (a[i] > a[j]) inv++;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp; end
    if (full) begin
      foreach (a[i]) exp_q.push_back(a[i]);
      exp_sw = inv;
    end
    for (int k = 0; k < 8; k++) begin
      s.in_valid = 1'b1;
      tmp = f[k];
      s.in_data = tmp[7:0];
      t = 0;
      while (!s.in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (!s.in_ready) chk("load_ready", 0, 1);
      @(posedge clk); #1;
    end
    if (hold) s.in_data = 8'h5a;
    else s.in_valid = 1'b0;
    if (full) begin
      chk("busy_E1", s.busy, 1);
      chk("in_ready_sort", s.in_ready, 0);
      n = 0;
      nb = 0;
      while (!s.out_valid && n < 200) begin
        if (s.busy) nb++;
        @(posedge clk); #1;
        n++;
      end
      chk("sort_lat", n, 28);
      chk("busy_cycles", nb, 28);
      chk("swaps", s.swap_count, exp_sw);
    end
  endtask

  task automatic drain(input bit toggle);
    int k, t, held;
    bit r, ph, stalled;
    k = 0; t = 0; held = 0; ph = 1'b1; stalled = 1'b0;
    while (k < 8 && t < 400) begin
      r = toggle ? ph : 1'b1;
      s.out_ready = r;
      if (stalled) begin
        chk("hold_valid", s.out_valid, 1);
        chk("hold_data", $signed(s.out_data), held);
      end
      chk("in_ready_drain", s.in_ready, 0);
      if (s.out_valid && r) begin
        if (exp_q.size() > 0) chk("out_data", $signed(s.out_data), exp_q.pop_front());
        else chk("q_empty", 1, 0);
        k++;
        stalled = 1'b0;
      end else begin
        stalled = s.out_valid;
        held = $signed(s.out_data);
      end
      ph = ~ph;
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", k, 8);
    s.out_ready = 1'b0;
    s.in_valid = 1'b0;
    chk("in_ready_after", s.in_ready, 1);
    chk("out_valid_after", s.out_valid, 0);
    chk("swaps_hold", s.swap_count, exp_sw);
  endtask

  initial begin
    s.in_valid = 1'b0;
    s.in_data = '0;
    s.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", s.in_ready, 1);
    chk("rst_out_valid", s.out_valid, 0);
    chk("rst_busy", s.busy, 0);
    chk("rst_swaps", s.swap_count, 0);
    chk("rst_out_data", s.out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    load(fa, 1'b0, 1'b1); drain(1'b0);
    load(fb, 1'b0, 1'b1); drain(1'b0);
    load(fc, 1'b0, 1'b1); drain(1'b0);
    load(fd, 1'b1, 1'b1); drain(1'b1);
    load(fx, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_pre_rst", s.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", s.in_ready, 1);
    chk("arst_out_valid", s.out_valid, 0);
    chk("arst_busy", s.busy, 0);
    chk("arst_swaps", s.swap_count, 0);
    chk("arst_out_data", s.out_data, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    load(fe, 1'b0, 1'b1); drain(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
